stopwatch_display_scan: RTL and testbench

STOPWATCH_DISPLAY_SCAN -- requirements
Module: stopwatch_display_scan

---
 rtl/stopwatch_display_scan.sv | 182 ++++++++++++++++++
 tb/tb_stopwatch_display_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 6-digit, 7-segment scanner for the stopwatch (MM:SS.hh).
//
// Each digit gets SCAN_DIV clocks. The first BLANK_CYCLES clocks of each slot have
// every anode off, so the previous digit cannot ghost onto the next one. The inputs
// are snapshotted once per frame, when the digit index wraps 5->0. The display reads
// only the snapshot, so a value is never shown half-updated. While the snapshotted
// overflow flag is set, the anodes blink with a half-period of BLINK_FRAMES frames.
//
// Ports:
//   CLK_50MHz           - system clock; all logic runs on its rising edge
//   reset               - synchronous, active-high reset
//   stopwatch_unit_mins - binary minutes (clamped to 99 for display)
//   stopwatch_unit_secs - binary seconds
//   stopwatch_unit_decs - binary hundredths (clamped to 99 for display)
//   stopwatch_overflow  - sticky overflow flag; enables blinking
//   seg_n               - segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n                - decimal point, active-low, registered
//   an_n                - digit anodes, active-low, registered (index i -> an_n[i])
//   frame_start         - one-clock pulse marking a fresh snapshot
module stopwatch_display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 83
) (
  input  logic       CLK_50MHz,
  input  logic       reset,
  input  logic [6:0] stopwatch_unit_mins,
  input  logic [5:0] stopwatch_unit_secs,
  input  logic [6:0] stopwatch_unit_decs,
  input  logic       stopwatch_overflow,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_start
);

  localparam int unsigned SlotW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  // Clamp to 99, then split into {tens, units}.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [6:0] c;
    logic [3:0] t;
    logic [3:0] u;
    c = (v > 7'd99) ? 7'd99 : v;
    t = 4'(c / 7'd10);
    u = 4'(c % 7'd10);
    return {t, u};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [SlotW-1:0]  slot_q, slot_d;
  logic [2:0]        idx_q, idx_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [6:0]        snap_mins_q, snap_decs_q;
  logic [5:0]        snap_secs_q;
  logic              snap_ovf_q;
  logic [6:0]        seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;
  logic [5:0]        an_n_q, an_n_d;
  logic              frame_start_q;

  logic slot_end;
  logic wrap;

  assign slot_end = (slot_q == SlotLast);
  assign wrap     = slot_end && (idx_q == 3'd5);

  // Slot / index / blink next-state.
  always_comb begin
    slot_d      = slot_q + 1'b1;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (slot_end) begin
      slot_d = '0;
      idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    if (wrap) begin
      if (!stopwatch_overflow) begin
        // The frame about to be captured is not overflowed: show it steadily.
        frame_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (snap_ovf_q) begin
        // Only frames that were themselves overflowed advance the blink count.
        if (frame_cnt_q == FrameLast) begin
          frame_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // Output decode from the current slot/index and the snapshot.
  logic [7:0] mins_bcd, secs_bcd, decs_bcd;
  logic [3:0] digit;

  always_comb begin
    mins_bcd = bcd_split(snap_mins_q);
    secs_bcd = bcd_split({1'b0, snap_secs_q});
    decs_bcd = bcd_split(snap_decs_q);
    case (idx_q)
      3'd0:    digit = decs_bcd[3:0];
      3'd1:    digit = decs_bcd[7:4];
      3'd2:    digit = secs_bcd[3:0];
      3'd3:    digit = secs_bcd[7:4];
      3'd4:    digit = mins_bcd[3:0];
      3'd5:    digit = mins_bcd[7:4];
      default: digit = 4'hf;
    endcase
    seg_n_d = seg_encode(digit);
    // Leading-zero suppression: the anode stays driven, only the segments go dark.
    if ((idx_q == 3'd5) && (mins_bcd[7:4] == 4'd0)) begin
      seg_n_d = 7'b1111111;
    end
    dp_n_d = !((idx_q == 3'd2) || (idx_q == 3'd4));
    an_n_d = ~(6'b000001 << idx_q);
    if ((32'(slot_q) < BLANK_CYCLES) || (snap_ovf_q && !blink_on_q)) begin
      an_n_d = 6'b111111;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (reset) begin
      slot_q        <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      snap_mins_q   <= '0;
      snap_secs_q   <= '0;
      snap_decs_q   <= '0;
      snap_ovf_q    <= 1'b0;
      seg_n_q       <= 7'b1111111;
      dp_n_q        <= 1'b1;
      an_n_q        <= 6'b111111;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_on_q    <= blink_on_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= wrap;
      if (wrap) begin
        snap_mins_q <= stopwatch_unit_mins;
        snap_secs_q <= stopwatch_unit_secs;
        snap_decs_q <= stopwatch_unit_decs;
        snap_ovf_q  <= stopwatch_overflow;
      end
    end
  end

  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench for stopwatch_display_scan (SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2).
// The stimulus pushes one record per expected lit digit, tagged with its frame number.
// The monitor pops a record at the first lit clock of each digit and compares it.
// Frames that should be dark get no records, so any lit digit in them is out of order.
module tb_stopwatch_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] mins = '0;
  logic [5:0] secs = '0;
  logic [6:0] decs = '0;
  logic       ovf = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_start;

  stopwatch_display_scan #(
    .SCAN_DIV    (4),
    .BLANK_CYCLES(1),
    .BLINK_FRAMES(2)
  ) dut (
    .CLK_50MHz          (clk),
    .reset              (reset),
    .stopwatch_unit_mins(mins),
    .stopwatch_unit_secs(secs),
    .stopwatch_unit_decs(decs),
    .stopwatch_overflow (ovf),
    .seg_n              (seg_n),
    .dp_n               (dp_n),
    .an_n               (an_n),
    .frame_start        (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         frame;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  // Digit glyphs 0..9; entry 10 is a blanked digit.
  localparam logic [6:0] SEG [11] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b1111111
  };

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Push the first n digits (index order 0..5) of the given frame.
  task automatic expect_frame(input int frame, input int n, input int d0, input int d1,
                              input int d2, input int d3, input int d4, input int d5);
    int         d[6];
    logic [5:0] one;
    exp_t       e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4; d[5] = d5;
    one = 6'd1;
    for (int i = 0; i < n; i++) begin
      e.frame = frame;
      e.an    = ~(one << i);
      e.seg   = SEG[d[i]];
      e.dp    = (i == 2 || i == 4) ? 1'b0 : 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 100);
    if (!frame_start) begin
      n_cmp++;
      n_mis++;
      $display("FAIL wait_frame: frame_start not seen within %0d clocks (got 0, want 1)", k);
    end
  endtask

  task automatic run_monitor();
    logic [5:0] prev_an;
    logic       prev_fs;
    logic       rst_seen;
    int         frame;
    exp_t       e;
    prev_an  = 6'h3f;
    prev_fs  = 1'b0;
    rst_seen = 1'b0;
    frame    = 0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        n_cmp++;
        if (an_n !== 6'h3f || seg_n !== 7'h7f || dp_n !== 1'b1 || frame_start !== 1'b0) begin
          n_mis++;
          $display("FAIL reset_idle: got an=%b seg=%b dp=%b fs=%b, want an=111111 seg=1111111 dp=1 fs=0",
                   an_n, seg_n, dp_n, frame_start);
        end
      end
      // A new lit digit: anode active and different from last clock.
      if (an_n !== 6'h3f && an_n !== prev_an) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL digit_event: unexpected lit digit frame=%0d an=%b seg=%b dp=%b (want none)",
                   frame, an_n, seg_n, dp_n);
        end else begin
          e = exp_q.pop_front();
          if (frame != e.frame || an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp ||
              prev_an !== 6'h3f) begin
            n_mis++;
            $display("FAIL digit_event: got frame=%0d an=%b seg=%b dp=%b prev_an=%b, want frame=%0d an=%b seg=%b dp=%b prev_an=111111",
                     frame, an_n, seg_n, dp_n, prev_an, e.frame, e.an, e.seg, e.dp);
          end
        end
      end
      if (frame_start === 1'b1) begin
        n_cmp++;
        if (prev_fs !== 1'b0) begin
          n_mis++;
          $display("FAIL frame_start_width: got high for 2+ clocks, want a 1-clock pulse");
        end
        frame++;
      end
      prev_fs = frame_start;
      prev_an = an_n;
      if (reset) begin
        frame   = 0;
        prev_an = 6'h3f;
        prev_fs = 1'b0;
      end
      rst_seen = reset;
    end
  endtask

  task automatic run_stimulus();
    // Held inputs during reset; frame 0 must still show zeros.
    mins = 7'd12; secs = 6'd34; decs = 7'd56; ovf = 1'b0;
    expect_frame(0, 6, 0, 0, 0, 0, 0, 10);
    expect_frame(1, 6, 6, 5, 4, 3, 2, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    wait_frame();                                   // frame 1
    mins = 7'd5; secs = 6'd7; decs = 7'd10;
    expect_frame(2, 6, 0, 1, 7, 0, 5, 10);
    expect_frame(3, 6, 0, 1, 7, 0, 5, 10);
    wait_frame();                                   // frame 2
    wait_frame();                                   // frame 3
    repeat (10) @(negedge clk);
    decs = 7'd11;                                   // mid-frame: must not show until frame 4
    expect_frame(4, 6, 1, 1, 7, 0, 5, 10);
    wait_frame();                                   // frame 4
    mins = 7'd99; secs = 6'd59; decs = 7'd100;
    expect_frame(5, 6, 9, 9, 9, 5, 9, 9);
    wait_frame();                                   // frame 5
    ovf = 1'b1;
    // Lit 6,7; dark 8,9; lit 10,11.
    expect_frame(6, 6, 9, 9, 9, 5, 9, 9);
    expect_frame(7, 6, 9, 9, 9, 5, 9, 9);
    expect_frame(10, 6, 9, 9, 9, 5, 9, 9);
    expect_frame(11, 6, 9, 9, 9, 5, 9, 9);
    repeat (6) wait_frame();                        // frames 6..11
    ovf = 1'b0;                                     // frame 12 would otherwise be dark
    expect_frame(12, 6, 9, 9, 9, 5, 9, 9);
    expect_frame(13, 4, 9, 9, 9, 5, 9, 9);          // reset lands in idx 3
    wait_frame();                                   // frame 12
    wait_frame();                                   // frame 13

    // One-clock reset at idx 3, slot 2.
    expect_frame(0, 6, 0, 0, 0, 0, 0, 10);
    expect_frame(1, 6, 9, 9, 9, 5, 9, 9);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_frame();                                   // frame 1 after reset
    wait_frame();                                   // frame 2 after reset
  endtask

  initial begin
    fork
      run_stimulus();
      run_monitor();
    join_any
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d digit records never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
